// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl: ECP5 EHXPLLL reset/lock supervisor and dynamic phase-step sequencer.
// Clocked from the reference clock so it keeps running while the PLL is unlocked.
module pll_phase_ctrl #(
   parameter int RST_CYCLES         = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int LOCK_TIMEOUT       = 65535,
   parameter int STEP_LOW           = 4,
   parameter int STEP_GAP           = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic [1:0] phasesel,
   output logic       phasedir,
   output logic       phasestep,
   output logic       phaseloadreg,
   output logic       sys_rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_sel,
   input  logic       req_dir,
   input  logic [7:0] req_steps,
   output logic       step_done,
   output logic       lock_lost,
   output logic       fail,
   output logic       busy
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int CMAX = max2(max2(RST_CYCLES, LOCK_STABLE_CYCLES),
                              max2(LOCK_TIMEOUT, max2(STEP_LOW, STEP_GAP)));
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] C_RST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] C_LSC = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] C_TO  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] C_LOW = CW'(STEP_LOW - 1);
   localparam logic [CW-1:0] C_GAP = CW'(STEP_GAP - 1);

   localparam logic [2:0] S_RESET   = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_STABLE  = 3'd2;
   localparam logic [2:0] S_READY   = 3'd3;
   localparam logic [2:0] S_SETUP   = 3'd4;
   localparam logic [2:0] S_STEPLO  = 3'd5;
   localparam logic [2:0] S_STEPGAP = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   logic          r_sync1;
   logic          r_sync2;
   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_rem;
   logic [1:0]    r_sel;
   logic          r_dir;
   logic          r_pll_rst;
   logic          r_sys_rst;
   logic          r_phasestep;
   logic          r_req_ready;
   logic          r_step_done;
   logic          r_lock_lost;
   logic          r_fail;
   logic          r_busy;

   logic [2:0]    w_state_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic          w_lock;
   logic          w_run;
   logic          w_accept;
   logic          w_lost;
   logic          w_timeout;
   logic          w_rem_dec;

   assign w_lock = r_sync2;
   assign w_run  = (r_state == S_READY)  || (r_state == S_SETUP) ||
                   (r_state == S_STEPLO) || (r_state == S_STEPGAP) ||
                   (r_state == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_accept    = 1'b0;
      w_lost      = 1'b0;
      w_timeout   = 1'b0;
      w_rem_dec   = 1'b0;
      case (r_state)
         S_RESET: begin
            if (r_cnt == C_RST) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
            end
         end
         S_WAIT: begin
            if (w_lock) begin
               w_state_nxt = S_STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_TO) begin
               w_state_nxt = S_RESET;
               w_cnt_nxt   = '0;
               w_timeout   = 1'b1;
            end
         end
         S_STABLE: begin
            if (!w_lock) begin
               w_state_nxt = S_WAIT;
               w_cnt_nxt   = '0;
            end else if (r_cnt == C_LSC) begin
               w_state_nxt = S_READY;
               w_cnt_nxt   = '0;
            end
         end
         S_READY: begin
            w_cnt_nxt = '0;
            if (req_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = (req_steps == 8'd0) ? S_DONE : S_SETUP;
            end
         end
         S_SETUP: begin
            if (r_cnt == C_GAP) begin
               w_state_nxt = S_STEPLO;
               w_cnt_nxt   = '0;
            end
         end
         S_STEPLO: begin
            if (r_cnt == C_LOW) begin
               w_state_nxt = S_STEPGAP;
               w_cnt_nxt   = '0;
               w_rem_dec   = 1'b1;
            end
         end
         S_STEPGAP: begin
            if (r_cnt == C_GAP) begin
               w_state_nxt = (r_rem != 8'd0) ? S_STEPLO : S_DONE;
               w_cnt_nxt   = '0;
            end
         end
         S_DONE: begin
            w_state_nxt = S_READY;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_RESET;
            w_cnt_nxt   = '0;
         end
      endcase
      // Lock loss overrides any step in flight and any same-cycle handshake.
      if (w_run && !w_lock) begin
         w_state_nxt = S_RESET;
         w_cnt_nxt   = '0;
         w_lost      = 1'b1;
         w_accept    = 1'b0;
         w_rem_dec   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_RESET;
         r_cnt   <= '0;
         r_rem   <= 8'd0;
         r_sel   <= 2'd0;
         r_dir   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_sel <= req_sel;
            r_dir <= req_dir;
            r_rem <= req_steps;
         end else if (w_rem_dec) begin
            r_rem <= r_rem - 8'd1;
         end
      end
   end

   // Outputs are registered from the next state so the PLL pins never glitch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pll_rst   <= 1'b1;
         r_sys_rst   <= 1'b1;
         r_phasestep <= 1'b1;
         r_req_ready <= 1'b0;
         r_step_done <= 1'b0;
         r_lock_lost <= 1'b0;
         r_fail      <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_pll_rst   <= (w_state_nxt == S_RESET);
         r_sys_rst   <= (w_state_nxt == S_RESET) ||
                        (w_state_nxt == S_WAIT) ||
                        (w_state_nxt == S_STABLE);
         r_phasestep <= (w_state_nxt != S_STEPLO);
         r_req_ready <= (w_state_nxt == S_READY);
         r_step_done <= (w_state_nxt == S_DONE);
         r_lock_lost <= w_lost;
         r_busy      <= (w_state_nxt != S_READY);
         if (w_timeout) begin
            r_fail <= 1'b1;
         end else if (w_state_nxt == S_READY) begin
            r_fail <= 1'b0;
         end
      end
   end

   assign pll_rst      = r_pll_rst;
   assign phasesel     = r_sel;
   assign phasedir     = r_dir;
   assign phasestep    = r_phasestep;
   assign phaseloadreg = 1'b1;
   assign sys_rst      = r_sys_rst;
   assign req_ready    = r_req_ready;
   assign step_done    = r_step_done;
   assign lock_lost    = r_lock_lost;
   assign fail         = r_fail;
   assign busy         = r_busy;

endmodule
